// File: rtl/wave_voice_sched.sv
// Time-multiplexes one wave_gen across NUM_VOICES voices and mixes their samples.
// Optional WAVE_SCHED_SAT_EN: saturate the narrowed mix instead of wrapping it.
module wave_voice_sched #(
  parameter  int NUM_VOICES = 4,
  parameter  int SHIFT      = 2,
  parameter  int TIMEOUT    = 1023,
  localparam int VW         = $clog2(NUM_VOICES)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_sample_tick,
  input  logic [NUM_VOICES-1:0] i_voice_en,
  input  logic                  i_cfg_we,
  input  logic [VW-1:0]         i_cfg_voice,
  input  logic [1:0]            i_cfg_sel,
  input  logic [31:0]           i_cfg_data,
  output logic                  o_gen_req_next,
  output logic [31:0]           o_gen_step,
  output logic [31:0]           o_gen_primscale,
  output logic [31:0]           o_gen_secscale,
  input  logic [15:0]           i_gen_data,
  input  logic                  i_gen_done,
  output logic [15:0]           o_mix_data,
  output logic                  o_mix_valid,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_gen_timeout
);

  localparam int AW = 16 + VW;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_OUTPUT
  } state_t;

  state_t r_state, w_next;

  logic [31:0] r_sh_step [NUM_VOICES];
  logic [31:0] r_sh_prim [NUM_VOICES];
  logic [31:0] r_sh_sec  [NUM_VOICES];
  logic [31:0] r_lv_step [NUM_VOICES];
  logic [31:0] r_lv_prim [NUM_VOICES];
  logic [31:0] r_lv_sec  [NUM_VOICES];

  logic [NUM_VOICES-1:0] r_en;
  logic [VW:0]           r_scan;
  logic [CW-1:0]         r_wait_cnt;
  logic signed [AW-1:0]  r_acc;
  logic [31:0]           r_gen_step, r_gen_prim, r_gen_sec;
  logic [15:0]           r_mix;
  logic                  r_overrun, r_timeout;

  logic w_start, w_scan_adv, w_load_gen, w_add, w_to, w_mix_load;
  logic w_req, w_mix_valid, w_busy, w_remain, w_cur_en;
  logic signed [AW-1:0] w_shifted;
  logic [15:0]          w_result;

  // A voice is only worth scanning if some enabled voice remains at or above r_scan.
  assign w_remain = |(r_en >> r_scan);
  assign w_cur_en = r_en[r_scan[VW-1:0]];

  localparam logic signed [AW-1:0] MAX16 = 32767;
  localparam logic signed [AW-1:0] MIN16 = -32768;

  assign w_shifted = r_acc >>> SHIFT;

`ifdef WAVE_SCHED_SAT_EN
  always_comb begin
    if (w_shifted > MAX16)      w_result = 16'h7FFF;
    else if (w_shifted < MIN16) w_result = 16'h8000;
    else                        w_result = 16'(w_shifted);
  end
`else
  assign w_result = 16'(w_shifted);
`endif

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_next      = r_state;
    w_start     = 1'b0;
    w_scan_adv  = 1'b0;
    w_load_gen  = 1'b0;
    w_add       = 1'b0;
    w_to        = 1'b0;
    w_mix_load  = 1'b0;
    w_req       = 1'b0;
    w_mix_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_sample_tick) begin
          w_start = 1'b1;
          w_next  = S_SCAN;
        end
      end
      S_SCAN: begin
        w_busy = 1'b1;
        if (!w_remain) begin
          w_mix_load = 1'b1;
          w_next     = S_OUTPUT;
        end else begin
          w_scan_adv = 1'b1;
          if (w_cur_en) begin
            w_load_gen = 1'b1;
            w_next     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_busy = 1'b1;
        w_req  = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (i_gen_done) begin
          w_add  = 1'b1;
          w_next = S_SCAN;
        end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
          w_to   = 1'b1;
          w_next = S_SCAN;
        end
      end
      S_OUTPUT: begin
        w_mix_valid = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // NOTE: the register banks are cleared on reset because a frame started
      // before any config write must present defined (zero) words to wave_gen.
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_sh_step[i] <= '0;
        r_sh_prim[i] <= '0;
        r_sh_sec[i]  <= '0;
        r_lv_step[i] <= '0;
        r_lv_prim[i] <= '0;
        r_lv_sec[i]  <= '0;
      end
      r_en       <= '0;
      r_scan     <= '0;
      r_wait_cnt <= '0;
      r_acc      <= '0;
      r_gen_step <= '0;
      r_gen_prim <= '0;
      r_gen_sec  <= '0;
      r_mix      <= '0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (i_cfg_we) begin
        case (i_cfg_sel)
          2'd0:    r_sh_step[i_cfg_voice] <= i_cfg_data;
          2'd1:    r_sh_prim[i_cfg_voice] <= i_cfg_data;
          2'd2:    r_sh_sec[i_cfg_voice]  <= i_cfg_data;
          default: ;
        endcase
      end
      // Live bank takes the pre-edge shadow, so a same-cycle write waits a frame.
      if (w_start) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          r_lv_step[i] <= r_sh_step[i];
          r_lv_prim[i] <= r_sh_prim[i];
          r_lv_sec[i]  <= r_sh_sec[i];
        end
        r_en   <= i_voice_en;
        r_acc  <= '0;
        r_scan <= '0;
      end
      if (w_scan_adv) r_scan <= r_scan + 1'b1;
      if (w_load_gen) begin
        r_gen_step <= r_lv_step[r_scan[VW-1:0]];
        r_gen_prim <= r_lv_prim[r_scan[VW-1:0]];
        r_gen_sec  <= r_lv_sec[r_scan[VW-1:0]];
        r_wait_cnt <= '0;
      end
      if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_add)      r_acc <= r_acc + AW'($signed(i_gen_data));
      if (w_to)       r_timeout <= 1'b1;
      if (i_sample_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
      if (w_mix_load) r_mix <= w_result;
    end
  end

  assign o_gen_req_next  = w_req;
  assign o_gen_step      = r_gen_step;
  assign o_gen_primscale = r_gen_prim;
  assign o_gen_secscale  = r_gen_sec;
  assign o_mix_data      = r_mix;
  assign o_mix_valid     = w_mix_valid;
  assign o_busy          = w_busy;
  assign o_overrun       = r_overrun;
  assign o_gen_timeout   = r_timeout;

endmodule
